// File: rtl/strip_frame_decoder.sv
// Oversampling decoder for the two-wire LED strip stream: locks onto the zero
// start frame and reports each 32-bit LED frame as brightness/colour fields.
module strip_frame_decoder #(
   parameter int NUM_PIXELS  = 64,
   parameter int IDX_W       = 6,
   parameter int START_ZEROS = 32,
   parameter int SAMPLE_EDGE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             led_clk,
   input  logic             led_data,
   output logic             pix_valid,
   output logic [IDX_W-1:0] pix_idx,
   output logic [4:0]       pix_bright,
   output logic [7:0]       pix_blue,
   output logic [7:0]       pix_green,
   output logic [7:0]       pix_red,
   output logic             frame_start,
   output logic             frame_done,
   output logic             frame_err
);

   localparam int ZR_W = $clog2(START_ZEROS + 1);
   localparam int PC_W = $clog2(NUM_PIXELS + 1);
   localparam logic [ZR_W-1:0] ZR_MAX  = ZR_W'(START_ZEROS);
   localparam logic [PC_W-1:0] PC_LAST = PC_W'(NUM_PIXELS - 1);

   typedef enum logic {HUNT = 1'b0, PIXEL = 1'b1} state_t;

   function automatic logic [ZR_W-1:0] zr_sat_inc(input logic [ZR_W-1:0] v);
      return (v >= ZR_MAX) ? ZR_MAX : v + ZR_W'(1);
   endfunction

   logic [2:0]       clk_sync_q, clk_sync_d;
   logic [1:0]       dat_sync_q, dat_sync_d;
   logic             bit_vld_q, bit_vld_d;
   logic             bit_q, bit_d;
   state_t           state_q, state_d;
   logic [ZR_W-1:0]  zero_run_q, zero_run_d;
   logic [4:0]       bit_cnt_q, bit_cnt_d;
   logic [PC_W-1:0]  pix_cnt_q, pix_cnt_d;
   // Header bits are checked on arrival, so only frame bits 3..30 are kept.
   logic [27:0]      sr_q, sr_d;
   logic             pix_valid_q, pix_valid_d;
   logic [IDX_W-1:0] pix_idx_q, pix_idx_d;
   logic [4:0]       bright_q, bright_d;
   logic [7:0]       blue_q, blue_d;
   logic [7:0]       green_q, green_d;
   logic [7:0]       red_q, red_d;
   logic             frame_start_q, frame_start_d;
   logic             frame_done_q, frame_done_d;
   logic             frame_err_q, frame_err_d;

   // Stage 0/1: synchronisers, edge detect and registered sample
   always_comb begin
      clk_sync_d = {clk_sync_q[1:0], led_clk};
      dat_sync_d = {dat_sync_q[0], led_data};
      if (SAMPLE_EDGE != 0) begin
         bit_vld_d = clk_sync_q[1] & ~clk_sync_q[2];
      end else begin
         bit_vld_d = ~clk_sync_q[1] & clk_sync_q[2];
      end
      bit_d = dat_sync_q[1];
   end

   // Stage 2: framing FSM and output registers
   always_comb begin
      state_d       = state_q;
      zero_run_d    = zero_run_q;
      bit_cnt_d     = bit_cnt_q;
      pix_cnt_d     = pix_cnt_q;
      sr_d          = sr_q;
      pix_valid_d   = 1'b0;
      frame_start_d = 1'b0;
      frame_done_d  = 1'b0;
      frame_err_d   = 1'b0;
      pix_idx_d     = pix_idx_q;
      bright_d      = bright_q;
      blue_d        = blue_q;
      green_d       = green_q;
      red_d         = red_q;
      if (bit_vld_q) begin
         sr_d = {sr_q[26:0], bit_q};
         case (state_q)
            HUNT: begin
               if (!bit_q) begin
                  zero_run_d = zr_sat_inc(zero_run_q);
               end else if (zero_run_q == ZR_MAX) begin
                  state_d       = PIXEL;
                  bit_cnt_d     = 5'd1;
                  pix_cnt_d     = '0;
                  zero_run_d    = '0;
                  frame_start_d = 1'b1;
               end else begin
                  zero_run_d = '0;
               end
            end
            PIXEL: begin
               if (bit_cnt_q < 5'd3 && !bit_q) begin
                  // The offending zero already counts toward the next start run.
                  frame_err_d = 1'b1;
                  state_d     = HUNT;
                  zero_run_d  = ZR_W'(1);
               end else if (bit_cnt_q == 5'd31) begin
                  pix_valid_d = 1'b1;
                  pix_idx_d   = IDX_W'(pix_cnt_q);
                  bright_d    = sr_q[27:23];
                  blue_d      = sr_q[22:15];
                  green_d     = sr_q[14:7];
                  red_d       = {sr_q[6:0], bit_q};
                  bit_cnt_d   = '0;
                  if (pix_cnt_q == PC_LAST) begin
                     frame_done_d = 1'b1;
                     state_d      = HUNT;
                     zero_run_d   = '0;
                  end else begin
                     pix_cnt_d = pix_cnt_q + PC_W'(1);
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync_q    <= '0;
         dat_sync_q    <= '0;
         bit_vld_q     <= 1'b0;
         bit_q         <= 1'b0;
         state_q       <= HUNT;
         zero_run_q    <= '0;
         bit_cnt_q     <= '0;
         pix_cnt_q     <= '0;
         sr_q          <= '0;
         pix_valid_q   <= 1'b0;
         pix_idx_q     <= '0;
         bright_q      <= '0;
         blue_q        <= '0;
         green_q       <= '0;
         red_q         <= '0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         clk_sync_q    <= clk_sync_d;
         dat_sync_q    <= dat_sync_d;
         bit_vld_q     <= bit_vld_d;
         bit_q         <= bit_d;
         state_q       <= state_d;
         zero_run_q    <= zero_run_d;
         bit_cnt_q     <= bit_cnt_d;
         pix_cnt_q     <= pix_cnt_d;
         sr_q          <= sr_d;
         pix_valid_q   <= pix_valid_d;
         pix_idx_q     <= pix_idx_d;
         bright_q      <= bright_d;
         blue_q        <= blue_d;
         green_q       <= green_d;
         red_q         <= red_d;
         frame_start_q <= frame_start_d;
         frame_done_q  <= frame_done_d;
         frame_err_q   <= frame_err_d;
      end
   end

   assign pix_valid   = pix_valid_q;
   assign pix_idx     = pix_idx_q;
   assign pix_bright  = bright_q;
   assign pix_blue    = blue_q;
   assign pix_green   = green_q;
   assign pix_red     = red_q;
   assign frame_start = frame_start_q;
   assign frame_done  = frame_done_q;
   assign frame_err   = frame_err_q;

endmodule
